// File: rtl/rhd_spi_pkg.sv
// Purpose : shared constants, ROM contents and frame FSM state for the RHD2000 responder model.
// Latency : n/a (declarations and a combinational ROM lookup only).
// Backpressure : n/a; no flow control exists on an SPI responder.
package rhd_spi_pkg;

    localparam int FRAME_BITS = 16;

    // Opcode field, command bits [15:14].
    localparam logic [1:0] OP_CONVERT = 2'b00;
    localparam logic [1:0] OP_MISC    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    // Full-word encodings of the 01-class commands.
    localparam logic [15:0] CMD_CLEAR     = 16'h6A00;
    localparam logic [15:0] CMD_CALIBRATE = 16'h5500;

    // Registers 0..WRITABLE_MAX are backed by RAM.
    localparam int WRITABLE_MAX = 21;

    // Read-only register contents.
    localparam logic [7:0] ROM_REG40 = 8'h49;  // 'I'
    localparam logic [7:0] ROM_REG41 = 8'h4E;  // 'N'
    localparam logic [7:0] ROM_REG42 = 8'h54;  // 'T'
    localparam logic [7:0] ROM_REG43 = 8'h41;  // 'A'
    localparam logic [7:0] ROM_REG44 = 8'h4E;  // 'N'
    localparam logic [7:0] ROM_REG60 = 8'h01;
    localparam logic [7:0] ROM_REG61 = 8'h00;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_IDLE,
        ST_ACTIVE
    } frame_state_t;

    // Read-only part of the register map; 62/63 come from the instance parameters.
    function automatic logic [7:0] rom_read(input logic [5:0] addr,
                                            input logic [7:0] num_amps,
                                            input logic [7:0] chip_id);
        logic [7:0] val;
        case (addr)
            6'd40:   val = ROM_REG40;
            6'd41:   val = ROM_REG41;
            6'd42:   val = ROM_REG42;
            6'd43:   val = ROM_REG43;
            6'd44:   val = ROM_REG44;
            6'd60:   val = ROM_REG60;
            6'd61:   val = ROM_REG61;
            6'd62:   val = num_amps;
            6'd63:   val = chip_id;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/rhd_chip_model.sv
// Purpose : one RHD2000 chip: MOSI capture, command decode, register RAM, sample counter,
//           two-deep result pipeline and MISO shift register.
// Latency : a command's result is shifted out two frames after the frame that carried it.
// Backpressure : none; the top hands in single-cycle edge strobes and the model always takes them.
//   ports: aclk/areset; load (frame start), sample (SCLK rise), shift (SCLK fall),
//   commit (good frame end), mosi (synchronized bit); word (command incl. bit being sampled),
//   miso_bit (current output bit, ungated).
import rhd_spi_pkg::*;

module rhd_chip_model #(
    parameter int NUM_AMPS = 32,
    parameter int CHIP_ID  = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        load,
    input  logic        sample,
    input  logic        shift,
    input  logic        commit,
    input  logic        mosi,
    output logic [15:0] word,
    output logic        miso_bit
);

    localparam logic [5:0] LAST_CH    = 6'(NUM_AMPS - 1);
    localparam logic [7:0] NUM_AMPS_B = 8'(NUM_AMPS);
    localparam logic [7:0] CHIP_ID_B  = 8'(CHIP_ID);
    localparam logic [5:0] WR_MAX_A   = 6'(WRITABLE_MAX);

    logic [15:0] mosi_sr;
    logic [15:0] miso_sr;
    logic [15:0] pipe_a;
    logic [15:0] pipe_b;
    logic [9:0]  sample_cnt;
    logic [7:0]  regs [0:WRITABLE_MAX];

    logic [5:0]  addr;
    logic [7:0]  rd_data;
    logic [15:0] result;
    logic        cnt_adv;
    logic        cnt_clr;
    logic        reg_wr;

    // When CS rises in the same cycle as the last SCLK rise, the bit being
    // sampled must already be part of the decoded word, so decode looks at
    // the next value of the shift register rather than its current one.
    assign word     = sample ? {mosi_sr[14:0], mosi} : mosi_sr;
    assign addr     = word[13:8];
    assign miso_bit = miso_sr[15];

    always_comb begin
        rd_data = rom_read(addr, NUM_AMPS_B, CHIP_ID_B);
        if (addr <= WR_MAX_A) begin
            rd_data = regs[addr[4:0]];
        end
    end

    always_comb begin
        result  = 16'h0000;
        cnt_adv = 1'b0;
        cnt_clr = 1'b0;
        reg_wr  = 1'b0;
        case (word[15:14])
            OP_CONVERT: begin
                result  = {word[13:8], sample_cnt};
                cnt_adv = (addr == LAST_CH);
            end
            OP_MISC: begin
                // CALIBRATE and every other 01 pattern return zero and do nothing.
                cnt_clr = (word == CMD_CLEAR);
            end
            OP_WRITE: begin
                // Writes outside the RAM are still echoed.
                result = {8'hFF, word[7:0]};
                reg_wr = (addr <= WR_MAX_A);
            end
            default: begin  // OP_READ
                result = {8'h00, rd_data};
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            mosi_sr    <= 16'h0000;
            miso_sr    <= 16'h0000;
            pipe_a     <= 16'h0000;
            pipe_b     <= 16'h0000;
            sample_cnt <= 10'd0;
            for (int i = 0; i <= WRITABLE_MAX; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (load) begin
                mosi_sr <= 16'h0000;
                miso_sr <= pipe_b;
            end else begin
                if (sample) begin
                    mosi_sr <= word;
                end
                if (shift) begin
                    miso_sr <= {miso_sr[14:0], 1'b0};
                end
            end

            if (commit) begin
                pipe_b <= pipe_a;
                pipe_a <= result;
                if (cnt_clr) begin
                    sample_cnt <= 10'd0;
                end else if (cnt_adv) begin
                    sample_cnt <= sample_cnt + 10'd1;  // wraps modulo 1024
                end
                if (reg_wr) begin
                    regs[addr[4:0]] <= word[7:0];
                end
            end
        end
    end

endmodule

// File: rtl/rhd_spi_responder.sv
// Purpose : SPI responder emulating two RHD2000 chips sharing CS/SCLK, with separate MOSI/MISO.
// Latency : SCLK pin edge to MISO pin change is 3 + MISO_DELAY aclk cycles; results lag commands by two frames.
// Backpressure : none; aclk must oversample SCLK by at least 4x (each SCLK phase >= 2 aclk cycles).
//   ports: aclk, areset (sync, active high); CS/SCLK/MOSI1/MOSI2 asynchronous pins;
//   MISO1/MISO2 result bits; cmd_strobe + cmd1/cmd2 on each accepted frame; frame_err on bad bit count.
import rhd_spi_pkg::*;

module rhd_spi_responder #(
    parameter int MISO_DELAY = 0,
    parameter int NUM_AMPS   = 32,
    parameter int CHIP_ID    = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        MOSI1,
    input  logic        MOSI2,
    output logic        MISO1,
    output logic        MISO2,
    output logic        cmd_strobe,
    output logic [15:0] cmd1,
    output logic [15:0] cmd2,
    output logic        frame_err
);

    // ---------------------------------------------------------------
    // Input conditioning. Synchronizers reset to 0 so that a CS pin that
    // is already low at reset release never looks like a fresh falling
    // edge; the ARM state additionally waits for CS to be seen high.
    // ---------------------------------------------------------------
    logic [1:0] cs_sync;
    logic [1:0] sclk_sync;
    logic [1:0] mosi1_sync;
    logic [1:0] mosi2_sync;
    logic       cs_q;
    logic       sclk_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            cs_sync    <= 2'b00;
            sclk_sync  <= 2'b00;
            mosi1_sync <= 2'b00;
            mosi2_sync <= 2'b00;
            cs_q       <= 1'b0;
            sclk_q     <= 1'b0;
        end else begin
            cs_sync    <= {cs_sync[0], CS};
            sclk_sync  <= {sclk_sync[0], SCLK};
            mosi1_sync <= {mosi1_sync[0], MOSI1};
            mosi2_sync <= {mosi2_sync[0], MOSI2};
            cs_q       <= cs_sync[1];
            sclk_q     <= sclk_sync[1];
        end
    end

    logic cs_s;
    logic cs_rise;
    logic cs_fall;
    logic sclk_rise;
    logic sclk_fall;

    assign cs_s      = cs_sync[1];
    assign cs_rise   =  cs_s & ~cs_q;
    assign cs_fall   = ~cs_s &  cs_q;
    assign sclk_rise =  sclk_sync[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[1] &  sclk_q;

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    frame_state_t state;
    logic [4:0]   bit_cnt;
    logic [4:0]   cnt_inc;
    logic [4:0]   cnt_eff;
    logic         frame_ok;
    logic [15:0]  word1;
    logic [15:0]  word2;

    assign cnt_inc  = (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
    // A bit sampled in the closing cycle still counts toward the frame.
    assign cnt_eff  = sclk_rise ? cnt_inc : bit_cnt;
    assign frame_ok = (cnt_eff == 5'(FRAME_BITS));

    logic chip_load;
    logic chip_sample;
    logic chip_shift;
    logic chip_commit;

    assign chip_load   = (state == ST_IDLE)   & cs_fall;
    assign chip_sample = (state == ST_ACTIVE) & sclk_rise;
    assign chip_shift  = (state == ST_ACTIVE) & sclk_fall;
    assign chip_commit = (state == ST_ACTIVE) & cs_rise & frame_ok;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ST_ARM;
            bit_cnt    <= 5'd0;
            cmd_strobe <= 1'b0;
            frame_err  <= 1'b0;
            cmd1       <= 16'h0000;
            cmd2       <= 16'h0000;
        end else begin
            cmd_strobe <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_ARM: begin
                    if (cs_s) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (cs_fall) begin
                        state   <= ST_ACTIVE;
                        bit_cnt <= 5'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (sclk_rise) begin
                        bit_cnt <= cnt_inc;
                    end
                    if (cs_rise) begin
                        state <= ST_IDLE;
                        if (frame_ok) begin
                            cmd_strobe <= 1'b1;
                            cmd1       <= word1;
                            cmd2       <= word2;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_ARM;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Chip models
    // ---------------------------------------------------------------
    logic chip1_miso;
    logic chip2_miso;

    rhd_chip_model #(
        .NUM_AMPS (NUM_AMPS),
        .CHIP_ID  (CHIP_ID)
    ) u_chip1 (
        .aclk     (aclk),
        .areset   (areset),
        .load     (chip_load),
        .sample   (chip_sample),
        .shift    (chip_shift),
        .commit   (chip_commit),
        .mosi     (mosi1_sync[1]),
        .word     (word1),
        .miso_bit (chip1_miso)
    );

    rhd_chip_model #(
        .NUM_AMPS (NUM_AMPS),
        .CHIP_ID  (CHIP_ID)
    ) u_chip2 (
        .aclk     (aclk),
        .areset   (areset),
        .load     (chip_load),
        .sample   (chip_sample),
        .shift    (chip_shift),
        .commit   (chip_commit),
        .mosi     (mosi2_sync[1]),
        .word     (word2),
        .miso_bit (chip2_miso)
    );

    // ---------------------------------------------------------------
    // MISO gating and cable-delay emulation. Output is forced low outside
    // an active frame; gating happens before the delay chain so that the
    // frame boundaries are delayed along with the data.
    // ---------------------------------------------------------------
    logic [1:0] miso_raw;
    logic [1:0] miso_dly;

    assign miso_raw = (state == ST_ACTIVE) ? {chip2_miso, chip1_miso} : 2'b00;

    generate
        if (MISO_DELAY == 0) begin : g_no_delay
            assign miso_dly = miso_raw;
        end else begin : g_delay
            logic [1:0] stage [MISO_DELAY];
            always_ff @(posedge aclk) begin
                if (areset) begin
                    for (int i = 0; i < MISO_DELAY; i++) begin
                        stage[i] <= 2'b00;
                    end
                end else begin
                    stage[0] <= miso_raw;
                    for (int i = 1; i < MISO_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end
            assign miso_dly = stage[MISO_DELAY-1];
        end
    endgenerate

    assign MISO1 = miso_dly[0];
    assign MISO2 = miso_dly[1];

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Purpose : directed bench for rhd_spi_responder, two builds (MISO_DELAY 0 and 3) on shared pins.
// Latency : checks 3 / 6 aclk from SCLK fall pin edge to MISO change.
// Backpressure : n/a.
module tb_rhd_spi_responder;

    logic aclk = 1'b0;
    logic areset;
    logic CS;
    logic SCLK;
    logic MOSI1;
    logic MOSI2;

    logic        miso1_d0, miso2_d0, strobe_d0, err_d0;
    logic [15:0] cmd1_d0, cmd2_d0;
    logic        miso1_d3, miso2_d3, strobe_d3, err_d3;
    logic [15:0] cmd1_d3, cmd2_d3;

    always #5 aclk = ~aclk;

    rhd_spi_responder #(.MISO_DELAY(0), .NUM_AMPS(32), .CHIP_ID(1)) dut0 (
        .aclk(aclk), .areset(areset), .CS(CS), .SCLK(SCLK), .MOSI1(MOSI1), .MOSI2(MOSI2),
        .MISO1(miso1_d0), .MISO2(miso2_d0), .cmd_strobe(strobe_d0),
        .cmd1(cmd1_d0), .cmd2(cmd2_d0), .frame_err(err_d0)
    );

    rhd_spi_responder #(.MISO_DELAY(3), .NUM_AMPS(32), .CHIP_ID(1)) dut3 (
        .aclk(aclk), .areset(areset), .CS(CS), .SCLK(SCLK), .MOSI1(MOSI1), .MOSI2(MOSI2),
        .MISO1(miso1_d3), .MISO2(miso2_d3), .cmd_strobe(strobe_d3),
        .cmd1(cmd1_d3), .cmd2(cmd2_d3), .frame_err(err_d3)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   strobe_cnt = 0;
    int   err_cnt = 0;
    logic watch_zero = 1'b0;
    logic miso_leak = 1'b0;
    int   fall_cyc = 0;
    int   fall_id = 0;
    logic lat_en = 1'b0;
    int   done0 = 0;
    int   done3 = 0;
    int   lat_min0 = 999, lat_max0 = 0, lat_min3 = 999, lat_max3 = 0;
    logic prev0 = 1'b0;
    logic prev3 = 1'b0;

    always @(posedge aclk) begin
        #1;
        cyc++;
        if (strobe_d0 === 1'b1) strobe_cnt++;
        if (err_d0 === 1'b1) err_cnt++;
        if (watch_zero && (miso1_d0 | miso2_d0 | miso1_d3 | miso2_d3) !== 1'b0) miso_leak = 1'b1;
        // First MISO1 change after each SCLK fall, per build.
        if (lat_en && done0 != fall_id && miso1_d0 !== prev0) begin
            done0 = fall_id;
            if (cyc - fall_cyc < lat_min0) lat_min0 = cyc - fall_cyc;
            if (cyc - fall_cyc > lat_max0) lat_max0 = cyc - fall_cyc;
        end
        if (lat_en && done3 != fall_id && miso1_d3 !== prev3) begin
            done3 = fall_id;
            if (cyc - fall_cyc < lat_min3) lat_min3 = cyc - fall_cyc;
            if (cyc - fall_cyc > lat_max3) lat_max3 = cyc - fall_cyc;
        end
        prev0 = miso1_d0;
        prev3 = miso1_d3;
    end

    // ---------------- SPI master ----------------
    logic [15:0] rx1_0, rx2_0, rx1_3, rx2_3;

    // SCLK phases of 4 aclk; MISO sampled 3 aclk into the high phase, a point
    // that is stable for both the 3- and 6-cycle builds.
    task automatic run_frame(input logic [15:0] w1, input logic [15:0] w2,
                             input int nbits, input int rst_after);
        strobe_cnt = 0;
        err_cnt    = 0;
        rx1_0 = '0; rx2_0 = '0; rx1_3 = '0; rx2_3 = '0;
        @(negedge aclk);
        CS = 1'b0;
        repeat (4) @(negedge aclk);
        for (int b = 0; b < nbits; b++) begin
            MOSI1 = w1[15-b];
            MOSI2 = w2[15-b];
            SCLK  = 1'b1;
            repeat (3) @(negedge aclk);
            rx1_0 = {rx1_0[14:0], miso1_d0};
            rx2_0 = {rx2_0[14:0], miso2_d0};
            rx1_3 = {rx1_3[14:0], miso1_d3};
            rx2_3 = {rx2_3[14:0], miso2_d3};
            @(negedge aclk);
            SCLK = 1'b0;
            if (rst_after == 0) begin
                fall_cyc = cyc;
                fall_id++;
                lat_en = 1'b1;
            end else begin
                lat_en = 1'b0;
            end
            if (b + 1 == rst_after) begin
                @(negedge aclk);
                areset = 1'b1;
                repeat (2) @(negedge aclk);
                areset = 1'b0;
                watch_zero = 1'b1;
                @(negedge aclk);
            end else begin
                repeat (4) @(negedge aclk);
            end
        end
        lat_en = 1'b0;
        CS = 1'b1;
        repeat (8) @(negedge aclk);
        watch_zero = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [15:0] e1, input logic [15:0] e2);
        check($sformatf("%s miso1 d0", tag), {16'h0, rx1_0}, {16'h0, e1});
        check($sformatf("%s miso2 d0", tag), {16'h0, rx2_0}, {16'h0, e2});
        check($sformatf("%s miso1 d3", tag), {16'h0, rx1_3}, {16'h0, e1});
        check($sformatf("%s miso2 d3", tag), {16'h0, rx2_3}, {16'h0, e2});
    endtask

    typedef struct {
        logic [15:0] m1;
        logic [15:0] m2;
        logic [15:0] e1;  // expected chip-1 MISO word in this frame
        logic [15:0] e2;
    } vec_t;

    localparam int NTBL = 15;
    localparam int NSWEEP = 99;
    vec_t        tbl [NTBL];
    logic [15:0] exp_q [$];
    logic [15:0] sweep_out [NSWEEP];
    logic [15:0] cmd;
    logic [15:0] expw;
    logic [9:0]  cnt_model;

    initial begin
        //              MOSI1     MOSI2     exp MISO1 exp MISO2
        tbl[0]  = '{16'hFF00, 16'hFD00, 16'h0000, 16'h0000};  // RD63 / RD61
        tbl[1]  = '{16'hE800, 16'hFD00, 16'h0000, 16'h0000};  // RD40
        tbl[2]  = '{16'hE900, 16'hFD00, 16'h0001, 16'h0000};  // RD41
        tbl[3]  = '{16'h85A5, 16'h8012, 16'h0049, 16'h0000};  // WR5=A5 / WR0=12
        tbl[4]  = '{16'hC500, 16'hC000, 16'h004E, 16'h0000};  // RD5 / RD0
        tbl[5]  = '{16'hC500, 16'hFD00, 16'hFFA5, 16'hFF12};
        tbl[6]  = '{16'hC500, 16'hFD00, 16'h00A5, 16'h0012};
        tbl[7]  = '{16'hC500, 16'hFD00, 16'h00A5, 16'h0000};
        tbl[8]  = '{16'hFE00, 16'hFC00, 16'h00A5, 16'h0000};  // RD62 / RD60
        tbl[9]  = '{16'hEC00, 16'hD500, 16'h00A5, 16'h0000};  // RD44 / RD21
        tbl[10] = '{16'h9677, 16'hC000, 16'h0020, 16'h0001};  // WR22 ignored / RD0
        tbl[11] = '{16'hD600, 16'hBF55, 16'h004E, 16'h0000};  // RD22 / WR63 ignored
        tbl[12] = '{16'h5500, 16'hFF00, 16'hFF77, 16'h0012};  // CALIBRATE / RD63
        tbl[13] = '{16'hFD00, 16'hFD00, 16'h0000, 16'hFF55};
        tbl[14] = '{16'hFD00, 16'hFD00, 16'h0000, 16'h0001};

        areset = 1'b1; CS = 1'b1; SCLK = 1'b0; MOSI1 = 1'b0; MOSI2 = 1'b0;
        repeat (5) @(negedge aclk);
        check("reset miso", {28'h0, miso1_d0, miso2_d0, miso1_d3, miso2_d3}, 32'h0);
        check("reset strobe/err", {30'h0, strobe_d0, err_d0}, 32'h0);
        check("reset cmd", {cmd1_d0, cmd2_d0}, 32'h0);
        areset = 1'b0;
        repeat (4) @(negedge aclk);
        check("idle miso after reset", {28'h0, miso1_d0, miso2_d0, miso1_d3, miso2_d3}, 32'h0);

        // Register map and pipeline table.
        for (int i = 0; i < NTBL; i++) begin
            run_frame(tbl[i].m1, tbl[i].m2, 16, 0);
            check_out($sformatf("tbl%0d", i), tbl[i].e1, tbl[i].e2);
            check($sformatf("tbl%0d cmd", i), {cmd1_d0, cmd2_d0}, {tbl[i].m1, tbl[i].m2});
            check($sformatf("tbl%0d strobe", i), strobe_cnt, 1);
            check($sformatf("tbl%0d err", i), err_cnt, 0);
        end

        // Truncated frame is invisible to the pipeline.
        run_frame(16'hFF00, 16'hFD00, 16, 0);
        run_frame(16'hE800, 16'hFD00, 16, 0);
        run_frame(16'hE900, 16'hFD00, 9, 0);
        check("trunc err width", err_cnt, 1);
        check("trunc strobe", strobe_cnt, 0);
        check("trunc cmd1 held", {16'h0, cmd1_d0}, 32'h0000E800);
        run_frame(16'hFD00, 16'hFD00, 16, 0);
        check_out("trunc+1", 16'h0001, 16'h0000);
        run_frame(16'hFD00, 16'hFD00, 16, 0);
        check_out("trunc+2", 16'h0049, 16'h0000);

        // Channel sweep: two passes, CLEAR, one more pass, two flush frames.
        cnt_model = 10'd0;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        for (int i = 0; i < NSWEEP; i++) begin
            if (i < 64)       cmd = {2'b00, 6'(i % 32), 8'h00};
            else if (i == 64) cmd = 16'h6A00;
            else if (i < 97)  cmd = {2'b00, 6'(i - 65), 8'h00};
            else              cmd = 16'hFD00;
            run_frame(cmd, 16'hFD00, 16, 0);
            expw = exp_q.pop_front();
            check($sformatf("sweep%0d d0", i), {16'h0, rx1_0}, {16'h0, expw});
            check($sformatf("sweep%0d d3", i), {16'h0, rx1_3}, {16'h0, expw});
            sweep_out[i] = rx1_0;
            if (cmd[15:14] == 2'b00) begin
                exp_q.push_back({cmd[13:8], cnt_model});
                if (cmd[13:8] == 6'd31) cnt_model = cnt_model + 10'd1;
            end else begin
                exp_q.push_back(16'h0000);
                if (cmd == 16'h6A00) cnt_model = 10'd0;
            end
        end
        check("convert3 pass1", {16'h0, sweep_out[5]}, 32'h00000C00);
        check("convert3 pass2", {16'h0, sweep_out[37]}, 32'h00000C01);
        check("convert3 after clear", {16'h0, sweep_out[70]}, 32'h00000C00);

        // Reset released mid-frame with CS still low.
        miso_leak = 1'b0;
        run_frame(16'hFF00, 16'hFD00, 16, 7);
        check("midrst strobe", strobe_cnt, 0);
        check("midrst err", err_cnt, 0);
        check("midrst miso low", {31'h0, miso_leak}, 32'h0);
        run_frame(16'hFF00, 16'hFD00, 16, 0);
        check("midrst+1 strobe", strobe_cnt, 1);
        check_out("midrst+1", 16'h0000, 16'h0000);
        run_frame(16'hE800, 16'hFD00, 16, 0);
        check_out("midrst+2", 16'h0000, 16'h0000);
        run_frame(16'hFD00, 16'hFD00, 16, 0);
        check_out("midrst+3", 16'h0001, 16'h0000);

        check("latency d0 min", lat_min0, 3);
        check("latency d0 max", lat_max0, 3);
        check("latency d3 min", lat_min3, 6);
        check("latency d3 max", lat_max3, 6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/rhd_spi_responder.md
Name: rhd_spi_responder

Overview:
- Synthesizable model of two Intan RHD2000-series chips, acting as the SPI responder to the rhd SPI master.
- Shares CS and SCLK across both chips; each chip has its own MOSI and returns its own MISO.
- Used in block-design loopback benches and on-board self-test, so that the controller's delay register and packet logic run against deterministic data.
- Oversamples SCLK, CS and MOSI in the aclk domain.

Parameters:
- MISO_DELAY, 0: extra aclk cycles inserted on both MISO outputs (0..7); emulates cable/round-trip delay.
- NUM_AMPS, 32: amplifier count; reported in ROM register 62, and sets the channel that advances the sample counter.
- CHIP_ID, 1: value of ROM register 63.

Ports:
- aclk  in  1  single clock; must run at ≥4× SCLK (56 MHz nominal for 14 MHz SCLK).
- areset  in  1  synchronous, active-high reset.
- CS  in  1  SPI chip select, active low.
- SCLK  in  1  SPI clock; idles low.
- MOSI1  in  1  command stream, chip 1.
- MOSI2  in  1  command stream, chip 2.
- MISO1  out  1  result stream, chip 1.
- MISO2  out  1  result stream, chip 2.
- cmd_strobe  out  1  one-cycle pulse when a complete 16-bit frame is accepted.
- cmd1  out  16  last accepted chip-1 command; held until the next strobe.
- cmd2  out  16  last accepted chip-2 command; held until the next strobe.
- frame_err  out  1  one-cycle pulse when a frame ends with a bit count other than 16.

Behaviour:
- Input conditioning:
  - CS, SCLK, MOSI1 and MOSI2 each pass through a 2-flop synchronizer, followed by a registered edge detect.
  - SCLK high and low phases must each be ≥2 aclk cycles.
- Frame FSM, states ARM / IDLE / ACTIVE:
  - Reset enters ARM.
  - ARM → IDLE when synchronized CS = 1. This prevents a partial frame from being accepted when reset is released mid-frame.
  - IDLE → ACTIVE on CS falling edge: clear bit_cnt (5 bits); load the MISO shift register with pipe_b; present its MSB.
  - ACTIVE, SCLK rising edge: shift MOSI in MSB-first; bit_cnt increments and saturates at 31.
  - ACTIVE, SCLK falling edge: shift the MISO register left; vacated bits fill with 0.
  - ACTIVE → IDLE on CS rising edge:
    - bit_cnt == 16: decode the command, pulse cmd_strobe, then advance the pipeline: pipe_b ← pipe_a; pipe_a ← result.
    - Otherwise: pulse frame_err; no decode, no pipeline advance, no register writes.
- Command decode (per chip, on the 16-bit word):
  - 00CCCCCC xxxxxxxx, CONVERT(C): result = {C[5:0], sample_cnt[9:0]}. sample_cnt increments, wrapping modulo 1024, after any CONVERT with C == NUM_AMPS-1.
  - 0110101000000000, CLEAR: result 0x0000; sample_cnt ← 0.
  - 0101010100000000, CALIBRATE, and any other 01 pattern: result 0x0000, no effect.
  - 10RRRRRR DDDDDDDD, WRITE: result {0xFF, D}. Registers 0..21 are written; writes to any other register are ignored but still echoed.
  - 11RRRRRR xxxxxxxx, READ: result {0x00, reg[R]}.
    - Registers 0..21 return RAM contents (reset value 0x00).
    - 40..44 return 0x49 0x4E 0x54 0x41 0x4E ("INTAN").
    - 60 returns 0x01; 61 returns 0x00; 62 returns NUM_AMPS; 63 returns CHIP_ID.
    - All other registers return 0x00.
- Pipeline: the result of the command in frame n is shifted out during frame n+2. This two-frame latency is fixed.
- MISO output:
  - Drives 0 while CS is high or in ARM.
  - Passes through a MISO_DELAY-deep register chain that resets to 0.
  - Total latency from an SCLK pin edge to a MISO pin change is 3 + MISO_DELAY aclk cycles.
- Reset values: MISO1/2 = 0, cmd_strobe = 0, frame_err = 0, cmd1/cmd2 = 0x0000. Pipes, register RAM and sample_cnt all reset to 0.
- Simultaneous events:
  - A CS rising edge in the same cycle as an SCLK rising edge: the bit is sampled first, then the frame closes.
  - areset overrides everything.

Decomposition:
- Package rhd_spi_pkg holds:
  - opcode constants (CONVERT, CLEAR, CALIBRATE, WRITE, READ);
  - the ROM constants for registers 40..44 and 60..63;
  - WRITABLE_MAX = 21;
  - the FSM state enum.
- Sub-module rhd_chip_model: one instance per chip. Contains the MOSI shift register, decode, register RAM, sample_cnt, pipe_a/pipe_b and the MISO shift register, and takes edge strobes from the top.
- The top holds the synchronizers, edge detects, frame FSM and MISO delay chains.

Test Plan:
- Chip 1 receives READ(63)=0xFF00, then READ(40)=0xE800, then READ(41)=0xE900 → chip 1 MISO carries 0x0001 in frame 3 and 0x0049 in frame 4; frames 1–2 carry 0x0000.
- Chip 1 receives WRITE(5,0xA5)=0x85A5, then READ(5)=0xC500 three times → chip 1 MISO carries 0xFFA5 in frame 3 and 0x00A5 in frame 4. In parallel, chip 2 receives WRITE(0,0x12) → chip 2 MISO carries 0xFF12 in frame 3, independent of chip 1.
- Channel sweep:
  - CONVERT ch 0..31, twice → CONVERT(3) returns 0x0C00 on pass 1 and 0x0C01 on pass 2.
  - Send CLEAR, then sweep again → CONVERT(3) returns 0x0C00.
- Truncated frame: raise CS after 9 SCLKs → frame_err pulses exactly 1 cycle, cmd_strobe stays 0, and the next two frames output the same data as without the truncated frame.
- Reset mid-frame: assert areset at bit 7 and release it while CS is still low → no strobe or error for that frame, MISO stays 0. The next full frame is accepted, and frames 1–2 after it return 0x0000.
- MISO_DELAY sweep: build with 0 and 3 → MISO edges occur 3 and 6 aclk cycles after the corresponding SCLK pin edge; data is otherwise identical.
